// File: rtl/wps_cmd_scheduler.sv
// Round-robin command scheduler: polls descriptor slots, launches DDR3/on-chip fetch
// plus wps_send, and writes done/error status back to the descriptor.
`timescale 1ns/1ps
module wps_cmd_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int BASE_ADDR      = 0,
  parameter int ADDR_W         = 13,
  parameter int POLL_INTERVAL  = 256,
  parameter int TIMEOUT_CYCLES = 16777216
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort_in,
  output logic [31:0]         usr_start_addr_out,
  output logic [31:0]         to_read_byte_out,
  output logic [31:0]         to_read_frame_num_out,
  output logic [31:0]         one_frame_byte_out,
  output logic                ddr3_read_start_out,
  output logic                onchip_mem_read_start_out,
  input  logic                ddr3_read_done_in,
  input  logic                onchip_mem_read_done_in,
  output logic                wps_send_start_out,
  output logic                busy_out,
  output logic [3:0]          active_slot_out,
  output logic                error_out,
  output logic                mem_cs,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_be,
  output logic [255:0]        mem_wdata,
  input  logic                mem_rd_valid,
  input  logic [255:0]        mem_rdata
);

  localparam logic [3:0]        LAST_SLOT = 4'(NUM_SLOTS - 1);
  localparam logic [31:0]       POLL_LAST = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0]       WD_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic              WD_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    ST_POLL_WAIT = 3'd0,
    ST_RD_REQ    = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_ACK_WR    = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_FETCH     = 3'd5,
    ST_UPDATE    = 3'd6
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  slot_r, slot_s, next_slot_s;
  logic [31:0] poll_cnt_r, poll_cnt_s;
  logic [31:0] wd_r, wd_s;
  logic [7:0]  status_r, status_s;
  logic        latch_s, done_sel_s;
  logic        src_r;
  logic [31:0] frames_r, bpf_r, total_r, saddr_r;
  logic [15:0] h_pix_r, v_line_r;
  logic        rd_req_s, ack_s, issue_s, upd_s;
  logic        unused_bits_s;

  // Geometry and flag bits are carried in the descriptor but not needed here.
  assign unused_bits_s = ^{mem_rdata[253:224], mem_rdata[63:0], h_pix_r, v_line_r};

  assign rd_req_s = (state_s == ST_RD_REQ);
  assign ack_s    = (state_s == ST_ACK_WR);
  assign issue_s  = (state_s == ST_ISSUE);
  assign upd_s    = (state_s == ST_UPDATE);

  // Next-state, slot, counter and status computation.
  always_comb begin
    next_slot_s = (slot_r == LAST_SLOT) ? 4'd0 : slot_r + 4'd1;
    done_sel_s  = src_r ? onchip_mem_read_done_in : ddr3_read_done_in;
    state_s     = state_r;
    slot_s      = slot_r;
    wd_s        = wd_r;
    status_s    = status_r;
    latch_s     = 1'b0;
    case (state_r)
      ST_POLL_WAIT: begin
        if (poll_cnt_r >= POLL_LAST) state_s = ST_RD_REQ;
        else                         state_s = ST_POLL_WAIT;
      end
      ST_RD_REQ: state_s = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (mem_rd_valid) begin
          if (mem_rdata[255]) begin
            latch_s = 1'b1;
            state_s = ST_ACK_WR;
          end else begin
            slot_s  = next_slot_s;
            state_s = ST_POLL_WAIT;
          end
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      ST_ACK_WR: state_s = ST_ISSUE;
      ST_ISSUE: begin
        wd_s    = 32'd0;
        state_s = ST_FETCH;
      end
      ST_FETCH: begin
        wd_s = wd_r + 32'd1;
        // Completion has priority over abort and watchdog expiry.
        if (done_sel_s) begin
          status_s = 8'h80;
          state_s  = ST_UPDATE;
        end else if (abort_in || (WD_EN && (wd_r >= WD_LAST))) begin
          status_s = 8'h40;
          state_s  = ST_UPDATE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_UPDATE: begin
        slot_s  = next_slot_s;
        state_s = ST_POLL_WAIT;
      end
      default: state_s = ST_POLL_WAIT;
    endcase
    if ((state_r == ST_POLL_WAIT) && (state_s == ST_POLL_WAIT)) poll_cnt_s = poll_cnt_r + 32'd1;
    else                                                        poll_cnt_s = 32'd0;
  end

  // Control state registers and latched descriptor fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_POLL_WAIT;
      slot_r     <= 4'd0;
      poll_cnt_r <= 32'd0;
      wd_r       <= 32'd0;
      status_r   <= 8'h00;
      src_r      <= 1'b0;
      frames_r   <= 32'd0;
      bpf_r      <= 32'd0;
      total_r    <= 32'd0;
      saddr_r    <= 32'd0;
      h_pix_r    <= 16'd0;
      v_line_r   <= 16'd0;
    end else begin
      state_r    <= state_s;
      slot_r     <= slot_s;
      poll_cnt_r <= poll_cnt_s;
      wd_r       <= wd_s;
      status_r   <= status_s;
      if (latch_s) begin
        src_r    <= mem_rdata[254];
        frames_r <= mem_rdata[223:192];
        bpf_r    <= mem_rdata[191:160];
        h_pix_r  <= mem_rdata[159:144];
        v_line_r <= mem_rdata[143:128];
        total_r  <= mem_rdata[127:96];
        saddr_r  <= mem_rdata[95:64];
      end
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_cs                    <= 1'b0;
      mem_rd                    <= 1'b0;
      mem_wr                    <= 1'b0;
      mem_addr                  <= '0;
      mem_be                    <= 32'd0;
      mem_wdata                 <= 256'd0;
      usr_start_addr_out        <= 32'd0;
      to_read_byte_out          <= 32'd0;
      to_read_frame_num_out     <= 32'd0;
      one_frame_byte_out        <= 32'd0;
      ddr3_read_start_out       <= 1'b0;
      onchip_mem_read_start_out <= 1'b0;
      wps_send_start_out        <= 1'b0;
      busy_out                  <= 1'b0;
      active_slot_out           <= 4'd0;
      error_out                 <= 1'b0;
    end else begin
      mem_cs <= rd_req_s | ack_s | upd_s;
      mem_rd <= rd_req_s;
      mem_wr <= ack_s | upd_s;
      if (rd_req_s | ack_s | upd_s) mem_addr <= BASE + ADDR_W'(slot_s);
      if (ack_s)      mem_be <= 32'h4000_0000;
      else if (upd_s) mem_be <= 32'hC000_0000;
      else            mem_be <= 32'd0;
      // ACK clears done/error (all-zero data); UPDATE clears start and posts status.
      if (upd_s) mem_wdata <= {8'h00, status_s, 240'd0};
      else       mem_wdata <= 256'd0;
      if (issue_s) begin
        usr_start_addr_out    <= saddr_r;
        to_read_byte_out      <= total_r;
        to_read_frame_num_out <= frames_r;
        one_frame_byte_out    <= bpf_r;
      end
      ddr3_read_start_out       <= issue_s & ~src_r;
      onchip_mem_read_start_out <= issue_s & src_r;
      wps_send_start_out        <= issue_s;
      busy_out        <= !((state_s == ST_POLL_WAIT) || (state_s == ST_RD_REQ) || (state_s == ST_RD_WAIT));
      active_slot_out <= slot_s;
      error_out       <= upd_s && (status_s == 8'h40);
    end
  end

endmodule

// File: tb/tb_wps_cmd_scheduler.sv
// Directed bench for wps_cmd_scheduler: descriptor memory model plus write/start scoreboards.
`timescale 1ns/1ps
module tb_wps_cmd_scheduler;
  localparam int NS = 4, BASE = 16, AW = 13, PI = 8, TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0, abort_in = 1'b0, ddr3_read_done_in = 1'b0, onchip_mem_read_done_in = 1'b0;
  logic mem_rd_valid = 1'b0;
  logic [255:0] mem_rdata = 256'd0;
  logic [31:0] usr_start_addr_out, to_read_byte_out, to_read_frame_num_out, one_frame_byte_out;
  logic ddr3_read_start_out, onchip_mem_read_start_out, wps_send_start_out, busy_out, error_out;
  logic [3:0] active_slot_out;
  logic mem_cs, mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_be;
  logic [255:0] mem_wdata;

  wps_cmd_scheduler #(.NUM_SLOTS(NS), .BASE_ADDR(BASE), .ADDR_W(AW), .POLL_INTERVAL(PI), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .abort_in(abort_in),
    .usr_start_addr_out(usr_start_addr_out), .to_read_byte_out(to_read_byte_out),
    .to_read_frame_num_out(to_read_frame_num_out), .one_frame_byte_out(one_frame_byte_out),
    .ddr3_read_start_out(ddr3_read_start_out), .onchip_mem_read_start_out(onchip_mem_read_start_out),
    .ddr3_read_done_in(ddr3_read_done_in), .onchip_mem_read_done_in(onchip_mem_read_done_in),
    .wps_send_start_out(wps_send_start_out), .busy_out(busy_out), .active_slot_out(active_slot_out),
    .error_out(error_out), .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic [31:0] be; logic [255:0] data; } wr_t;
  typedef struct packed { logic ddr; logic onchip; logic [127:0] fields; } st_t;
  typedef struct packed { logic [1:0] idx; logic [255:0] data; } host_t;

  wr_t exp_wr_q[$];
  st_t exp_st_q[$];
  host_t host_q[$];
  logic [AW-1:0] rd_q[$];
  int rd_cyc_q[$];
  logic [255:0] mem [4];

  int tests = 0, fails = 0, cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, wr_cyc = 0, st_cnt = 0, st_cyc = 0, err_cnt = 0, vcyc = 0;
  logic [1:0] rd_idx = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model, write scoreboard and start-pulse scoreboard, all sampled mid-cycle.
  always @(negedge clk) begin
    host_t h;
    wr_t w;
    st_t s;
    logic [1:0] wi;
    while (host_q.size() > 0) begin
      h = host_q.pop_front();
      mem[h.idx] = h.data;
    end
    mem_rd_valid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        mem_rd_valid = 1'b1;
        mem_rdata = mem[rd_idx];
        vcyc = cyc;
      end
    end
    if (mem_cs && mem_rd) begin
      rd_q.push_back(mem_addr);
      rd_cyc_q.push_back(cyc);
      rd_idx = 2'(mem_addr - AW'(BASE));
      rd_cnt = 1 + int'(rd_idx[0]);
    end
    if (mem_cs && mem_wr) begin
      wr_cnt++;
      wr_cyc = cyc;
      if (exp_wr_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_write: observed addr %0h be %0h, expected no write", mem_addr, mem_be);
      end else begin
        w = exp_wr_q.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_be", mem_be, w.be);
        chk("wr_data", mem_wdata, w.data);
      end
      wi = 2'(mem_addr - AW'(BASE));
      for (int b = 0; b < 32; b++) if (mem_be[b]) mem[wi][b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
    if (ddr3_read_start_out || onchip_mem_read_start_out || wps_send_start_out) begin
      st_cnt++;
      st_cyc = cyc;
      if (exp_st_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_start: observed ddr %0b onchip %0b wps %0b, expected none",
               ddr3_read_start_out, onchip_mem_read_start_out, wps_send_start_out);
      end else begin
        s = exp_st_q.pop_front();
        chk("st_ddr", ddr3_read_start_out, s.ddr);
        chk("st_onchip", onchip_mem_read_start_out, s.onchip);
        chk("st_wps", wps_send_start_out, 1'b1);
        chk("st_fields", {usr_start_addr_out, to_read_byte_out, to_read_frame_num_out, one_frame_byte_out}, s.fields);
      end
    end
    if (error_out) err_cnt++;
  end

  function automatic logic [255:0] desc(input logic src, input logic [31:0] frames, bpf, total, addr);
    logic [255:0] d;
    d = 256'd0;
    d[255] = 1'b1;
    d[254] = src;
    d[247] = 1'b1;
    d[246] = 1'b1;
    d[223:192] = frames;
    d[191:160] = bpf;
    d[159:144] = 16'd640;
    d[143:128] = 16'd480;
    d[127:96] = total;
    d[95:64] = addr;
    return d;
  endfunction

  task automatic host_set(input int idx, input logic [255:0] data);
    host_t h;
    h.idx = 2'(idx);
    h.data = data;
    host_q.push_back(h);
  endtask

  task automatic expect_run(input int slot, input logic [255:0] d, input logic [7:0] status, input bit with_update);
    wr_t w;
    st_t s;
    w.addr = AW'(BASE + slot);
    w.be = 32'h4000_0000;
    w.data = 256'd0;
    exp_wr_q.push_back(w);
    s.ddr = ~d[254];
    s.onchip = d[254];
    s.fields = {d[95:64], d[127:96], d[223:192], d[191:160]};
    exp_st_q.push_back(s);
    if (with_update) begin
      w.be = 32'hC000_0000;
      w.data = {8'h00, status, 240'd0};
      exp_wr_q.push_back(w);
    end
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n0;
    bit ok;
    n0 = st_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (st_cnt != n0) ok = 1'b1;
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_write(input string tag, input int budget);
    int n0;
    bit ok;
    n0 = wr_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (wr_cnt != n0) ok = 1'b1;
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_read(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (rd_q.size() > 0) ok = 1'b1;
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic pulse(input logic ddr, input logic onchip, input logic ab, output int c);
    @(negedge clk);
    ddr3_read_done_in = ddr;
    onchip_mem_read_done_in = onchip;
    abort_in = ab;
    c = cyc;
    @(negedge clk);
    ddr3_read_done_in = 1'b0;
    onchip_mem_read_done_in = 1'b0;
    abort_in = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy_out, active_slot_out, mem_cs, mem_rd, mem_wr, error_out, ddr3_read_start_out,
                        onchip_mem_read_start_out, wps_send_start_out, mem_addr, mem_be}, 256'd0);
    chk({tag, "_fields"}, {usr_start_addr_out, to_read_byte_out, to_read_frame_num_out, one_frame_byte_out}, 256'd0);
    chk({tag, "_wdata"}, mem_wdata, 256'd0);
  endtask

  initial begin
    int rel, d, n, s;
    logic [255:0] d0, d1, d2, d3;
    for (int i = 0; i < NS; i++) host_set(i, 256'd0);
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // Single descriptor in slot 2, DDR3 source.
    d2 = desc(1'b0, 32'd3, 32'h100, 32'h300, 32'h1000);
    host_set(2, d2);
    expect_run(2, d2, 8'h80, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    wait_start("wait_start_s2", 500);
    chk("first_read_cyc", rd_cyc_q[0], rel + PI);
    for (int i = 0; i < 3; i++) chk("poll_order_s2", rd_q.pop_front(), AW'(BASE + i));
    rd_cyc_q.delete();
    chk("ack_cyc", wr_cyc, vcyc + 1);
    chk("issue_cyc", st_cyc, vcyc + 2);
    repeat (48) @(negedge clk);
    chk("busy_fetch", busy_out, 1'b1);
    chk("slot_fetch", active_slot_out, 4'd2);
    pulse(1'b1, 1'b0, 1'b0, d);
    wait_write("wait_update_s2", 20);
    chk("done_to_update", wr_cyc, d + 1);
    chk("no_error_s2", err_cnt, 0);
    wait_read("wait_read_after_s2", 50);
    chk("wrap_read_slot", rd_q.pop_front(), AW'(BASE + 3));
    chk("read_after_update_cyc", rd_cyc_q.pop_front(), wr_cyc + 1 + PI);
    @(negedge clk);
    chk("busy_poll", busy_out, 1'b0);

    // Slots 0 and 3 with on-chip source; spurious DDR3 done and done+abort together.
    @(negedge clk);
    rst_n = 1'b0;
    d0 = desc(1'b1, 32'd5, 32'h40, 32'h140, 32'h2000);
    d3 = desc(1'b1, 32'd7, 32'h80, 32'h380, 32'h3000);
    host_set(0, d0);
    host_set(1, 256'd0);
    host_set(2, 256'd0);
    host_set(3, d3);
    repeat (2) @(negedge clk);
    rd_q.delete();
    rd_cyc_q.delete();
    expect_run(0, d0, 8'h80, 1'b1);
    rst_n = 1'b1;
    wait_start("wait_start_s0", 200);
    n = wr_cnt;
    pulse(1'b1, 1'b0, 1'b0, d);
    repeat (4) @(negedge clk);
    chk("spurious_ddr_done", wr_cnt, n);
    chk("busy_after_spurious", busy_out, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, d);
    wait_write("wait_update_s0", 20);
    chk("onchip_done_to_update", wr_cyc, d + 1);
    expect_run(3, d3, 8'h80, 1'b1);
    wait_start("wait_start_s3", 300);
    for (int i = 0; i < 4; i++) chk("poll_order_s03", rd_q.pop_front(), AW'(BASE + i));
    chk("slot_fetch_s3", active_slot_out, 4'd3);
    repeat (10) @(negedge clk);
    pulse(1'b0, 1'b1, 1'b1, d);
    wait_write("wait_update_s3", 20);
    chk("done_beats_abort_err", err_cnt, 0);

    // Abort outside FETCH is ignored; abort inside FETCH posts error.
    n = wr_cnt;
    pulse(1'b0, 1'b0, 1'b1, d);
    chk("abort_idle", wr_cnt, n);
    d1 = desc(1'b0, 32'd2, 32'h20, 32'h40, 32'h4000);
    host_set(1, d1);
    expect_run(1, d1, 8'h40, 1'b1);
    wait_start("wait_start_s1", 300);
    repeat (5) @(negedge clk);
    pulse(1'b0, 1'b0, 1'b1, d);
    wait_write("wait_update_s1", 20);
    chk("abort_to_update", wr_cyc, d + 1);
    chk("abort_error_pulse", err_cnt, 1);

    // Watchdog expiry with no completion.
    d2 = desc(1'b0, 32'd9, 32'h10, 32'h90, 32'h5000);
    host_set(2, d2);
    expect_run(2, d2, 8'h40, 1'b1);
    wait_start("wait_start_to", 300);
    s = st_cyc;
    wait_write("wait_update_to", 200);
    chk("timeout_cyc", wr_cyc, s + 1 + TO);
    chk("timeout_error_pulse", err_cnt, 2);

    // Reset in the middle of a fetch.
    d3 = desc(1'b0, 32'd1, 32'h8, 32'h8, 32'h6000);
    host_set(3, d3);
    expect_run(3, d3, 8'h00, 1'b0);
    wait_start("wait_start_rst", 300);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    n = wr_cnt;
    @(negedge clk);
    chk_zero("rst_mid_fetch");
    repeat (3) @(negedge clk);
    rd_q.delete();
    rd_cyc_q.delete();
    rst_n = 1'b1;
    rel = cyc;
    wait_read("wait_read_after_rst", 50);
    chk("restart_slot0", rd_q.pop_front(), AW'(BASE));
    chk("restart_read_cyc", rd_cyc_q.pop_front(), rel + PI);
    chk("no_write_on_reset", wr_cnt, n);
    chk("exp_wr_drained", exp_wr_q.size(), 0);
    chk("exp_st_drained", exp_st_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
